thresh_ctrl: RTL and testbench

THRESH_CTRL -- requirements
Module: thresh_ctrl

---
 rtl/thresh_pkg.sv | 8 +
 rtl/seq_divider.sv | 58 +++++
 rtl/thresh_ctrl.sv | 118 +++++++++++
 tb/tb_thresh_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/thresh_pkg.sv
// Shared types and sizing for the auto-threshold controller.
package thresh_pkg;
    typedef enum logic [1:0] {IDLE, DIVIDE, APPLY} state_t;

    localparam int SUM_W      = 32;
    localparam int DIV_CYCLES = 32;
    localparam int THRESH_W   = 9;
endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses DIV_CYCLES cycles after start.
module seq_divider
    import thresh_pkg::*;
#(
    parameter int DIVIDEND_W = SUM_W,
    parameter int DIVISOR_W  = 21
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [DIVIDEND_W-1:0] dividend_in,
    input  logic [DIVISOR_W-1:0]  divisor_in,
    output logic [DIVIDEND_W-1:0] quotient_out,
    output logic                  done_out
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_div;
    logic [DIVIDEND_W-1:0] r_quo;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_done;

    logic [DIVISOR_W:0]    w_shift;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_diff;

    // Remainder is always below the divisor, so the trial difference fits DIVISOR_W bits.
    assign w_shift = {r_rem, r_quo[DIVIDEND_W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_diff  = w_shift[DIVISOR_W-1:0] - r_div;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (start_in) begin
            r_rem  <= '0;
            r_div  <= divisor_in;
            r_quo  <= dividend_in;
            r_cnt  <= CNT_W'(DIV_CYCLES);
            r_done <= 1'b0;
        end else if (r_cnt != '0) begin
            r_rem  <= w_ge ? w_diff : w_shift[DIVISOR_W-1:0];
            r_quo  <= {r_quo[DIVIDEND_W-2:0], w_ge};
            r_cnt  <= r_cnt - CNT_W'(1);
            r_done <= (r_cnt == CNT_W'(1));
        end else begin
            r_done <= 1'b0;
        end
    end

    assign quotient_out = r_quo;
    assign done_out     = r_done;
endmodule

// File: rtl/thresh_ctrl.sv
// Per-frame mean-luma threshold: accumulate, divide, add offset, clamp; manual override.
// New auto threshold lands 34 cycles after frame end; frames ending while busy are dropped.
module thresh_ctrl
    import thresh_pkg::*;
#(
    parameter logic [THRESH_W-1:0] DEFAULT_THRESH = 9'd128,
    parameter int                  MAX_PIX_W      = 21
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                y_valid_in,
    input  logic [7:0]          y_in,
    input  logic                frame_end_in,
    input  logic [8:0]          offset_in,
    input  logic                manual_in,
    input  logic [THRESH_W-1:0] manual_thresh_in,
    output logic [THRESH_W-1:0] thresh_out,
    output logic                thresh_update_out,
    output logic                busy_out,
    output logic                overrun_out
);
    state_t                r_state, w_state_nxt;
    logic [SUM_W-1:0]      r_sum, w_sum_nxt;
    logic [MAX_PIX_W-1:0]  r_cnt, w_cnt_nxt;
    logic                  w_acc;
    logic                  w_start, w_apply, w_div_done;
    logic [SUM_W-1:0]      w_quot;
    logic [7:0]            w_mean;
    logic [10:0]           w_biased;
    logic [THRESH_W-1:0]   w_clamped;
    logic [THRESH_W-1:0]   r_auto, r_thresh;
    logic                  r_upd, r_ovr;

    // Once the count saturates the frame stops accumulating, keeping sum/count consistent.
    always_comb begin
        w_acc     = y_valid_in && !(&r_cnt);
        w_sum_nxt = r_sum + (w_acc ? SUM_W'(y_in) : '0);
        w_cnt_nxt = r_cnt + MAX_PIX_W'(w_acc);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || frame_end_in) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else begin
            r_sum <= w_sum_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_end_in && (w_cnt_nxt != '0)) begin
                    w_start     = 1'b1;
                    w_state_nxt = DIVIDE;
                end
            end
            DIVIDE: if (w_div_done) w_state_nxt = APPLY;
            APPLY: begin
                w_apply     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    seq_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (MAX_PIX_W)
    ) u_div (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (w_start),
        .dividend_in  (w_sum_nxt),
        .divisor_in   (w_cnt_nxt),
        .quotient_out (w_quot),
        .done_out     (w_div_done)
    );

    // 11-bit two's complement covers mean (0..255) plus offset (-256..255).
    always_comb begin
        w_mean   = (|w_quot[SUM_W-1:8]) ? 8'hFF : w_quot[7:0];
        w_biased = {3'b000, w_mean} + {{2{offset_in[8]}}, offset_in};
        if (w_biased[10])             w_clamped = '0;
        else if (w_biased[9:8] != '0) w_clamped = 9'd255;
        else                          w_clamped = {1'b0, w_biased[7:0]};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_auto   <= DEFAULT_THRESH;
            r_thresh <= DEFAULT_THRESH;
            r_upd    <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_upd <= w_apply && !manual_in;
            if (w_apply)                          r_auto <= w_clamped;
            if (frame_end_in && r_state != IDLE)  r_ovr  <= 1'b1;
            if (manual_in)                        r_thresh <= manual_thresh_in;
            else if (w_apply)                     r_thresh <= w_clamped;
            else                                  r_thresh <= r_auto;
        end
    end

    assign thresh_out        = r_thresh;
    assign thresh_update_out = r_upd;
    assign busy_out          = (r_state != IDLE);
    assign overrun_out       = r_ovr;
endmodule

// File: tb/tb_thresh_ctrl.sv
// Directed bench for thresh_ctrl with hand-computed expected thresholds.
module tb_thresh_ctrl;
    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       y_valid_in;
    logic [7:0] y_in;
    logic       frame_end_in;
    logic [8:0] offset_in;
    logic       manual_in;
    logic [8:0] manual_thresh_in;
    logic [8:0] thresh_out;
    logic       thresh_update_out;
    logic       busy_out;
    logic       overrun_out;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;
    int p0;

    thresh_ctrl dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .y_valid_in        (y_valid_in),
        .y_in              (y_in),
        .frame_end_in      (frame_end_in),
        .offset_in         (offset_in),
        .manual_in         (manual_in),
        .manual_thresh_in  (manual_thresh_in),
        .thresh_out        (thresh_out),
        .thresh_update_out (thresh_update_out),
        .busy_out          (busy_out),
        .overrun_out       (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) if (thresh_update_out) pulse_cnt++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // n samples of constant luma, frame_end on the last; returns just after edge T.
    task automatic send_frame(input int n, input logic [7:0] y);
        for (int i = 0; i < n; i++) begin
            y_valid_in   = 1'b1;
            y_in         = y;
            frame_end_in = (i == n - 1);
            tick();
        end
        y_valid_in   = 1'b0;
        frame_end_in = 1'b0;
    endtask

    // From just after edge T: verify nothing at T+33, the new value and pulse at T+34.
    task automatic expect_apply(input string tag, input logic [8:0] exp_thr, input logic [8:0] prev_thr);
        repeat (33) tick();
        check_val({tag, "_t33_thr"}, thresh_out, prev_thr);
        check_val({tag, "_t33_upd"}, thresh_update_out, 0);
        check_val({tag, "_t33_busy"}, busy_out, 1);
        tick();
        check_val({tag, "_thr"}, thresh_out, exp_thr);
        check_val({tag, "_upd"}, thresh_update_out, 1);
        check_val({tag, "_idle"}, busy_out, 0);
        tick();
        check_val({tag, "_upd_drop"}, thresh_update_out, 0);
    endtask

    initial begin
        logic [7:0] ys [3];
        rst_in = 1'b1; y_valid_in = 1'b0; y_in = '0; frame_end_in = 1'b0;
        offset_in = '0; manual_in = 1'b0; manual_thresh_in = '0;
        tick(); tick();
        check_val("rst_thr", thresh_out, 128);
        check_val("rst_upd", thresh_update_out, 0);
        check_val("rst_busy", busy_out, 0);
        check_val("rst_ovr", overrun_out, 0);
        rst_in = 1'b0;
        tick();

        // Empty frame: no division, no pulse.
        p0 = pulse_cnt;
        frame_end_in = 1'b1;
        tick();
        frame_end_in = 1'b0;
        check_val("empty_busy0", busy_out, 0);
        repeat (36) tick();
        check_val("empty_busy1", busy_out, 0);
        check_val("empty_thr", thresh_out, 128);
        check_val("empty_pulses", pulse_cnt - p0, 0);

        // 16 x 100 -> 100.
        send_frame(16, 8'd100);
        expect_apply("s1", 9'd100, 9'd128);
        check_val("s1_ovr", overrun_out, 0);

        // (10+20+31)/3 = 20 truncated, +5 -> 25.
        ys = '{8'd10, 8'd20, 8'd31};
        offset_in = 9'd5;
        for (int i = 0; i < 3; i++) begin
            y_valid_in = 1'b1; y_in = ys[i]; frame_end_in = (i == 2);
            tick();
        end
        y_valid_in = 1'b0; frame_end_in = 1'b0;
        expect_apply("mix", 9'd25, 9'd100);

        // Clamp low: 10 - 20 -> 0. Clamp high: 250 + 20 -> 255.
        offset_in = 9'h1EC;
        send_frame(8, 8'd10);
        expect_apply("clamp_lo", 9'd0, 9'd25);
        offset_in = 9'd20;
        send_frame(8, 8'd250);
        expect_apply("clamp_hi", 9'd255, 9'd0);
        offset_in = 9'd0;

        // Overrun: second frame_end at T+10 is dropped and clears the pre-T+10 samples.
        p0 = pulse_cnt;
        send_frame(4, 8'd40);
        for (int i = 1; i <= 10; i++) begin
            y_valid_in = 1'b1; y_in = 8'd200; frame_end_in = (i == 10);
            tick();
        end
        y_valid_in = 1'b0; frame_end_in = 1'b0;
        check_val("ovr_set", overrun_out, 1);
        check_val("ovr_busy", busy_out, 1);
        repeat (23) tick();
        check_val("ovr_t33_upd", thresh_update_out, 0);
        tick();
        check_val("ovr_thr", thresh_out, 40);
        check_val("ovr_upd", thresh_update_out, 1);
        repeat (6) tick();
        check_val("ovr_one_pulse", pulse_cnt - p0, 1);
        send_frame(4, 8'd60);
        expect_apply("post_ovr", 9'd60, 9'd40);
        check_val("ovr_sticky", overrun_out, 1);

        // Manual override, auto mean still computed underneath.
        p0 = pulse_cnt;
        manual_in = 1'b1; manual_thresh_in = 9'd200;
        tick();
        check_val("man_thr", thresh_out, 200);
        send_frame(4, 8'd70);
        repeat (36) tick();
        check_val("man_hold", thresh_out, 200);
        check_val("man_pulses", pulse_cnt - p0, 0);
        manual_in = 1'b0;
        tick();
        check_val("man_revert", thresh_out, 70);

        // Reset mid-divide aborts.
        send_frame(4, 8'd90);
        repeat (14) tick();
        check_val("abort_busy_pre", busy_out, 1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check_val("abort_thr", thresh_out, 128);
        check_val("abort_busy", busy_out, 0);
        check_val("abort_ovr", overrun_out, 0);
        p0 = pulse_cnt;
        repeat (25) tick();
        check_val("abort_pulses", pulse_cnt - p0, 0);
        check_val("abort_thr_end", thresh_out, 128);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
